// File: rtl/local_mem_xbar.sv
// local_mem_xbar
// Word-interleaved crossbar with a round-robin arbiter per bank. It connects
// NUM_PORTS OBI requesters to NUM_BANKS local-memory banks that each answer in
// a single cycle.
//
// Handshake: a port request is accepted in the cycle where port_req_i and
// port_gnt_o are both high. Its response (port_rvalid_o, plus port_rdata_o for
// a read) arrives exactly one cycle later. A request that is not granted must
// hold req/we/be/addr/wdata stable until it is granted. The bank side uses the
// same req/gnt -> rvalid protocol.
//
// Ports (flattened arrays; port or bank n occupies slice n):
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   port_req_i/we_i/be_i     requester valid, write enable, byte enables
//   port_addr_i/wdata_i      requester byte address, write data
//   port_gnt_o               request accepted this cycle
//   port_rvalid_o/rdata_o    response valid, read data
//   bank_req_o/we_o/be_o     bank request, write enable, byte enables
//   bank_addr_o/wdata_o      in-bank byte address, write data
//   bank_gnt_i               bank accepts the current request
//   bank_rvalid_i/rdata_i    bank response valid, read data
module local_mem_xbar #(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned NUM_BANKS = 4,
    parameter int unsigned SIZE_BYTE = 1024
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [NUM_PORTS-1:0]    port_req_i,
    input  logic [NUM_PORTS-1:0]    port_we_i,
    input  logic [4*NUM_PORTS-1:0]  port_be_i,
    input  logic [32*NUM_PORTS-1:0] port_addr_i,
    input  logic [32*NUM_PORTS-1:0] port_wdata_i,
    output logic [NUM_PORTS-1:0]    port_gnt_o,
    output logic [NUM_PORTS-1:0]    port_rvalid_o,
    output logic [32*NUM_PORTS-1:0] port_rdata_o,
    output logic [NUM_BANKS-1:0]    bank_req_o,
    output logic [NUM_BANKS-1:0]    bank_we_o,
    output logic [4*NUM_BANKS-1:0]  bank_be_o,
    output logic [32*NUM_BANKS-1:0] bank_addr_o,
    output logic [32*NUM_BANKS-1:0] bank_wdata_o,
    input  logic [NUM_BANKS-1:0]    bank_gnt_i,
    input  logic [NUM_BANKS-1:0]    bank_rvalid_i,
    input  logic [32*NUM_BANKS-1:0] bank_rdata_i
);

    localparam int unsigned BANK_SEL  = $clog2(NUM_BANKS);
    localparam int unsigned BANK_ADDR = $clog2(SIZE_BYTE / NUM_BANKS / 4);
    localparam int unsigned PW        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    // Address decode for each port.
    logic [BANK_SEL-1:0]  port_bank  [NUM_PORTS];
    logic [BANK_ADDR-1:0] port_waddr [NUM_PORTS];

    // Arbitration results for each bank.
    logic [NUM_PORTS-1:0] cand    [NUM_BANKS];
    logic [NUM_BANKS-1:0] win_vld;
    logic [PW-1:0]        win_idx [NUM_BANKS];

    // Arbiter and response-routing state.
    logic [PW-1:0]        rr_q  [NUM_BANKS];
    logic [PW-1:0]        rr_d  [NUM_BANKS];
    logic [PW-1:0]        tag_q [NUM_BANKS];
    logic [PW-1:0]        tag_d [NUM_BANKS];
    logic [NUM_BANKS-1:0] tag_vld_q;
    logic [NUM_BANKS-1:0] tag_vld_d;

    // Address bits [1:0] and the bits above the memory size are unused on
    // purpose; this XOR keeps them visible to lint.
    logic unused_addr;
    assign unused_addr = ^port_addr_i;

    always_comb begin
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            port_bank[p]  = port_addr_i[32*p+2 +: BANK_SEL];
            port_waddr[p] = port_addr_i[32*p+2+BANK_SEL +: BANK_ADDR];
        end
    end

    // The winner is the first candidate found by scanning from rr_q[b],
    // wrapping modulo NUM_PORTS. This path uses only port inputs and rr_q, so
    // bank_req_o never depends on bank_gnt_i.
    always_comb begin
        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            cand[b]    = '0;
            win_vld[b] = 1'b0;
            win_idx[b] = '0;
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                cand[b][p] = port_req_i[p] && (port_bank[p] == BANK_SEL'(b));
            end
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                if (!win_vld[b] && cand[b][(int'(rr_q[b]) + i) % NUM_PORTS]) begin
                    win_vld[b] = 1'b1;
                    win_idx[b] = PW'((int'(rr_q[b]) + i) % NUM_PORTS);
                end
            end
        end
    end

    // Bank-side mux: forward the winner's request. Every field stays zero
    // when the bank has no candidate.
    always_comb begin
        bank_req_o   = '0;
        bank_we_o    = '0;
        bank_be_o    = '0;
        bank_addr_o  = '0;
        bank_wdata_o = '0;
        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            bank_req_o[b] = win_vld[b];
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                if (win_vld[b] && (win_idx[b] == PW'(p))) begin
                    bank_we_o[b]                        = port_we_i[p];
                    bank_be_o[4*b +: 4]                 = port_be_i[4*p +: 4];
                    bank_addr_o[32*b+2 +: BANK_ADDR]    = port_waddr[p];
                    bank_wdata_o[32*b +: 32]            = port_wdata_i[32*p +: 32];
                end
            end
        end
    end

    // Grant routing. A port requests exactly one bank, so at most one bank
    // term can be set for it.
    always_comb begin
        port_gnt_o = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            for (int unsigned b = 0; b < NUM_BANKS; b++) begin
                if (bank_gnt_i[b] && win_vld[b] && (win_idx[b] == PW'(p))) begin
                    port_gnt_o[p] = 1'b1;
                end
            end
        end
    end

    // Next state: after each accepted access, move the pointer to the port
    // after the winner and remember the winner for the response.
    always_comb begin
        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            rr_d[b]      = rr_q[b];
            tag_d[b]     = tag_q[b];
            tag_vld_d[b] = 1'b0;
            if (bank_gnt_i[b] && bank_req_o[b]) begin
                rr_d[b]      = (int'(win_idx[b]) + 1 >= NUM_PORTS) ? '0 : PW'(int'(win_idx[b]) + 1);
                tag_d[b]     = win_idx[b];
                tag_vld_d[b] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned b = 0; b < NUM_BANKS; b++) begin
                rr_q[b]  <= '0;
                tag_q[b] <= '0;
            end
            tag_vld_q <= '0;
        end else begin
            for (int unsigned b = 0; b < NUM_BANKS; b++) begin
                rr_q[b]  <= rr_d[b];
                tag_q[b] <= tag_d[b];
            end
            tag_vld_q <= tag_vld_d;
        end
    end

    // Response routing. A bank response with no tagged access behind it is
    // dropped.
    always_comb begin
        port_rvalid_o = '0;
        port_rdata_o  = '0;
        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                if (bank_rvalid_i[b] && tag_vld_q[b] && (tag_q[b] == PW'(p))) begin
                    port_rvalid_o[p]         = 1'b1;
                    port_rdata_o[32*p +: 32] = bank_rdata_i[32*b +: 32];
                end
            end
        end
    end

    // A bank must never answer without an accepted access on record.
    for (genvar gb = 0; gb < NUM_BANKS; gb++) begin : g_rvalid_chk
        a_rvalid_tagged : assert property (
            @(posedge clk_i) disable iff (!rst_ni)
            !(bank_rvalid_i[gb] && !tag_vld_q[gb])
        );
    end

endmodule

// File: doc/local_mem_xbar.md
# local_mem_xbar

Word-interleaved crossbar and per-bank round-robin arbiter between NUM_PORTS OBI requesters (compute-unit lanes/LSU ports) and the NUM_BANKS single-cycle local-memory banks. Routes each request to its bank by address, arbitrates conflicts per bank, and returns read data to the winning port one cycle after grant. Sits between the compute-unit load/store path and `mem_banks`.

## Interface
- NUM_PORTS, 4, number of requester ports (≥1)
- NUM_BANKS, 4, number of banks (power of two, ≥2)
- SIZE_BYTE, 1024, total local memory bytes (power of two)
- Derived: BANK_SEL = log2(NUM_BANKS); BANK_ADDR = log2(SIZE_BYTE/NUM_BANKS/4)

Ports (arrays flattened, port/bank p at slice p):
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- port_req_i  in  NUM_PORTS  request valid
- port_we_i  in  NUM_PORTS  write enable
- port_be_i  in  4*NUM_PORTS  byte enables
- port_addr_i  in  32*NUM_PORTS  byte address
- port_wdata_i  in  32*NUM_PORTS  write data
- port_gnt_o  out  NUM_PORTS  request accepted this cycle
- port_rvalid_o  out  NUM_PORTS  response valid
- port_rdata_o  out  32*NUM_PORTS  read data
- bank_req_o  out  NUM_BANKS  request to bank
- bank_we_o  out  NUM_BANKS  write enable
- bank_be_o  out  4*NUM_BANKS  byte enables
- bank_addr_o  out  32*NUM_BANKS  in-bank byte address
- bank_wdata_o  out  32*NUM_BANKS  write data
- bank_gnt_i  in  NUM_BANKS  bank grant
- bank_rvalid_i  in  NUM_BANKS  bank response valid
- bank_rdata_i  in  32*NUM_BANKS  bank read data

## Operation
- Bank select: bank = port_addr[2+BANK_SEL-1:2] (word interleaved). Bits [1:0] and bits above 2+BANK_SEL+BANK_ADDR-1 ignored.
- In-bank address: bank_addr_o = {zeros, port_addr[2+BANK_SEL+BANK_ADDR-1:2+BANK_SEL], 2'b00}.
- Per bank b, candidates = ports with req=1 and bank select = b. Winner = first candidate at or after rr_ptr[b] (wrapping modulo NUM_PORTS). Combinational from current inputs.
- bank_req_o[b] = any candidate; we/be/addr/wdata from winner; all bank outputs 0 when no candidate.
- port_gnt_o[p] = bank_gnt_i[b] & (p is winner of b). At most one grant per bank per cycle; a port is granted by at most one bank.
- On bank_gnt_i[b] & bank_req_o[b]: rr_ptr[b] <= (winner+1) mod NUM_PORTS; tag[b] <= winner, tag_vld[b] <= 1. Otherwise tag_vld[b] <= 0.
- Response: bank_rvalid_i[b] & tag_vld[b] → port_rvalid_o[tag[b]] = 1, port_rdata_o[tag[b]] = bank_rdata_i[b]. Writes also produce rvalid (rdata don't-care).
- A port receives at most one rvalid per cycle (one outstanding per port by construction: grant then response next cycle).
- bank_rvalid_i with tag_vld=0: dropped, no port rvalid; simulation assertion fires.
- Non-granted requesters must hold req/addr/wdata stable (OBI); arbiter keeps no state for them.

## Timing
- Reset: rr_ptr all 0, tag_vld all 0, tag 0. All outputs combinational; with req=0 everywhere all outputs 0.
- Request-to-grant: 0 cycles when bank free and port wins; grant-to-rvalid: exactly 1 cycle (bank latency).
- Banks grant every other cycle (IDLE/RVALID); per-bank throughput 1 access / 2 cycles; different banks in parallel.
- Fairness: a continuously requesting port is granted within NUM_PORTS bank grants of its bank.
- Reset asserted mid-transaction: tags cleared; pending responses discarded (bank also resets).
- No combinational loop: port_gnt_o depends on bank_gnt_i; bank_req_o depends only on port inputs and rr_ptr.

## Test plan
- Single read: port0 req addr 0x10 (bank 0, word 1), bank 0 gnt → port_gnt_o=0001 same cycle, bank_addr_o[0]=0x4; next cycle rvalid on port0 with bank_rdata 0xDEADBEEF.
- Parallel: ports 0..3 read 0x0,0x4,0x8,0xC → all four granted same cycle, each rvalid next cycle with its bank's data.
- Conflict: all 4 ports hold req to 0x20 (bank 0) → grants in order 0,1,2,3 on successive bank grants (every 2 cycles); rdata routed to matching port each time.
- Round-robin wrap: rr_ptr[0]=3, ports 1 and 3 req bank 0 → port 3 wins, then port 1; ptr becomes 0 then 2.
- Write: port2 we=1 be=0011 addr 0x14 wdata 0x1234_5678 → bank 1 sees we=1, be=0011, addr 0x4, wdata passed; port2 rvalid next cycle.
- Reset mid-op: assert rst_ni low in the cycle after grant → no port rvalid; after release, outputs 0 and rr_ptr 0.
